param_frame_ctrl: RTL

//   Receives the host parameter frame byte-by-byte from the UART receiver, checks header and checksum,

---
 rtl/param_frame_pkg.sv | 19 +
 rtl/param_frame_ctrl_tmo.sv | 36 +++
 rtl/param_frame_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/param_frame_pkg.sv
// Shared definitions for the host parameter frame controller.
//   - Default header bytes, words per frame and inter-byte timeout.
//   - FSM state encoding, which is also exported on the controller's debug port.
package param_frame_pkg;

  localparam int         NWORDS_DEF  = 6;
  localparam logic [7:0] HDR0_DEF    = 8'hA5;
  localparam logic [7:0] HDR1_DEF    = 8'h5A;
  localparam int         TIMEOUT_DEF = 50000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_PUSH    = 3'd4
  } state_e;

endpackage

// File: rtl/param_frame_ctrl_tmo.sv
// Inter-byte timeout counter for the frame controller.
//   clk, rst_n : clock, async active-low reset
//   arm_i      : count while high (frame in progress); counter held at 0 otherwise
//   load_i     : byte received; reloads the counter and suppresses expiry
//   expire_o   : 1-cycle pulse when TIMEOUT cycles have passed without a byte
module rx_timeout_cnt
  import param_frame_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arm_i,
  input  logic load_i,
  output logic expire_o
);

  localparam int            TW   = $clog2(TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // A byte arriving in the expiry cycle wins: load_i masks the pulse.
  assign expire_o = arm_i && !load_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!arm_i || load_i || expire_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/param_frame_ctrl.sv
// Host parameter frame controller.
// Receives HDR0 HDR1 P0..P(2*NWORDS-1) CSUM, checks header and 8-bit checksum,
// then pushes NWORDS 16-bit words {P(2k),P(2k+1)} into the parameter store.
//   clk, rst_n  : clock, async active-low reset
//   rx_data     : received byte
//   rx_valid    : 1-cycle strobe per byte; there is no back-pressure, a byte
//                 is consumed (or dropped) in the cycle its strobe is high
//   clr         : sync abort; drops wr_en so the store clears
//   wr_data     : word to store, qualified by wr_flag
//   wr_flag     : write strobe, one per word
//   wr_en       : store enable; set on push entry, cleared only by clr/reset
//   frame_ok    : pulse with the last wr_flag of an accepted frame
//   frame_err   : pulse on checksum mismatch or inter-byte timeout
//   busy        : state != IDLE
//   dbg_state_o : current FSM state (state_e encoding)
module param_frame_ctrl
  import param_frame_pkg::*;
#(
  parameter int         WIDTH   = 16,
  parameter int         NWORDS  = NWORDS_DEF,
  parameter logic [7:0] HDR0    = HDR0_DEF,
  parameter logic [7:0] HDR1    = HDR1_DEF,
  parameter int         TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             clr,
  output logic [WIDTH-1:0] wr_data,
  output logic             wr_flag,
  output logic             wr_en,
  output logic             frame_ok,
  output logic             frame_err,
  output logic             busy,
  output logic [2:0]       dbg_state_o
);

  localparam int             NBYTES    = 2 * NWORDS;
  localparam int             CW        = $clog2(NBYTES);
  localparam int             WIW       = $clog2(NWORDS);
  localparam logic [CW-1:0]  LAST_BYTE = CW'(NBYTES - 1);
  localparam logic [WIW-1:0] LAST_WORD = WIW'(NWORDS - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       sum_q, sum_d;
  logic [WIW-1:0]   widx_q, widx_d;
  logic [7:0]       buf_q [NBYTES];
  logic             buf_we;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic             wr_flag_q, wr_flag_d;
  logic             wr_en_q, wr_en_d;
  logic             frame_ok_q, frame_ok_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q;
  logic             tmo_arm, tmo_exp;
  logic [CW-1:0]    rd_hi_idx, rd_lo_idx;

  assign tmo_arm = (state_q == ST_HDR) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);

  rx_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .arm_i    (tmo_arm),
    .load_i   (rx_valid),
    .expire_o (tmo_exp)
  );

  // Word k lives in bytes 2k (MSB) and 2k+1 (LSB).
  assign rd_hi_idx = {widx_q, 1'b0};
  assign rd_lo_idx = {widx_q, 1'b1};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    widx_d      = widx_q;
    buf_we      = 1'b0;
    wr_data_d   = wr_data_q;
    wr_flag_d   = 1'b0;
    wr_en_d     = wr_en_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    if (clr) begin
      // Abort anything, including a push; the store clears as wr_en falls.
      state_d = ST_IDLE;
      wr_en_d = 1'b0;
    end else if (tmo_exp) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_valid && rx_data == HDR0) state_d = ST_HDR;
        end
        ST_HDR: begin
          if (rx_valid) begin
            if (rx_data == HDR1) begin
              state_d = ST_PAYLOAD;
              cnt_d   = '0;
              sum_d   = '0;
            end else if (rx_data != HDR0) begin
              state_d = ST_IDLE;   // a repeated HDR0 keeps us here to resync
            end
          end
        end
        ST_PAYLOAD: begin
          if (rx_valid) begin
            buf_we = 1'b1;
            sum_d  = sum_q + rx_data;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_BYTE) state_d = ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (rx_valid) begin
            if (rx_data == sum_q) begin
              state_d = ST_PUSH;
              widx_d  = '0;
              wr_en_d = 1'b1;      // high before the first strobe
            end else begin
              state_d     = ST_IDLE;
              frame_err_d = 1'b1;
            end
          end
        end
        ST_PUSH: begin
          // Incoming bytes are dropped here.
          wr_flag_d = 1'b1;
          wr_data_d = WIDTH'({buf_q[rd_hi_idx], buf_q[rd_lo_idx]});
          widx_d    = widx_q + 1'b1;
          if (widx_q == LAST_WORD) begin
            frame_ok_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sum_q       <= '0;
      widx_q      <= '0;
      wr_data_q   <= '0;
      wr_flag_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < NBYTES; i++) buf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      widx_q      <= widx_d;
      wr_data_q   <= wr_data_d;
      wr_flag_q   <= wr_flag_d;
      wr_en_q     <= wr_en_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      busy_q      <= (state_d != ST_IDLE);
      if (buf_we) buf_q[cnt_q] <= rx_data;
    end
  end

  assign wr_data     = wr_data_q;
  assign wr_flag     = wr_flag_q;
  assign wr_en       = wr_en_q;
  assign frame_ok    = frame_ok_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule
